lcd_writer: RTL

//  Consumes 9-bit words from the upstream word source over valid/ready and drives an
//  HD44780-compatible character LCD bus. Word bit 8 = RS (0 command, 1 data), bits 7:0 = byte.

---
 rtl/lcd_writer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/lcd_writer.sv
// lcd_writer: accepts {RS, byte} words over valid/ready and drives an
// HD44780-style LCD bus with setup / enable / hold timing, followed by the
// controller execution wait. Define LCD_4BIT_EN to send each word as two
// nibbles on lcd_db_o[7:4] (4-bit bus mode).
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | ready for a word, bus idle, rs/db hold the last word
// SETUP   | rs/db stable, en low, before the enable strobe
// PULSE   | en high
// HOLD    | en low again, rs/db still held
// WAIT    | controller execution time (long for clear/home)
module lcd_writer #(
    parameter int SETUP_CYCLES     = 2,
    parameter int EN_CYCLES        = 12,
    parameter int HOLD_CYCLES      = 2,
    parameter int EXEC_CYCLES      = 2000,
    parameter int LONG_EXEC_CYCLES = 82000
) (
    input  logic       clock_i,
    input  logic       rst_i,
    input  logic [8:0] data_i,
    input  logic       valid_i,
    output logic       ready_o,
    output logic       busy_o,
    output logic       lcd_rs_o,
    output logic       lcd_rw_o,
    output logic       lcd_en_o,
    output logic [7:0] lcd_db_o
);

    localparam int M_SE   = (SETUP_CYCLES > EN_CYCLES) ? SETUP_CYCLES : EN_CYCLES;
    localparam int M_SEH  = (M_SE > HOLD_CYCLES) ? M_SE : HOLD_CYCLES;
    localparam int M_SEHX = (M_SEH > EXEC_CYCLES) ? M_SEH : EXEC_CYCLES;
    localparam int M_ALL  = (M_SEHX > LONG_EXEC_CYCLES) ? M_SEHX : LONG_EXEC_CYCLES;
    localparam int CNT_W  = $clog2(M_ALL) + 1;

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] EN_LOAD    = CNT_W'(EN_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] EXEC_LOAD  = CNT_W'(EXEC_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(LONG_EXEC_CYCLES - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_PULSE = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             long_exec;
`ifdef LCD_4BIT_EN
    logic [3:0]       low_nib;
    logic             second_nib;
`endif

    // The LCD is only ever written, never read back.
    assign lcd_rw_o = 1'b0;

    // Sequencer: every output is registered; the down-counter times each phase.
    always_ff @(posedge clock_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            long_exec <= 1'b0;
            ready_o   <= 1'b0;
            busy_o    <= 1'b0;
            lcd_rs_o  <= 1'b0;
            lcd_en_o  <= 1'b0;
            lcd_db_o  <= '0;
`ifdef LCD_4BIT_EN
            low_nib    <= '0;
            second_nib <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (valid_i && ready_o) begin
                        lcd_rs_o  <= data_i[8];
                        // clear (0x01) and home (0x02/0x03) need the long wait
                        long_exec <= ~data_i[8] && (data_i[7:2] == 6'd0);
`ifdef LCD_4BIT_EN
                        lcd_db_o   <= {data_i[7:4], 4'h0};
                        low_nib    <= data_i[3:0];
                        second_nib <= 1'b0;
`else
                        lcd_db_o  <= data_i[7:0];
`endif
                        ready_o   <= 1'b0;
                        busy_o    <= 1'b1;
                        cnt       <= SETUP_LOAD;
                        state     <= ST_SETUP;
                    end else begin
                        ready_o <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        lcd_en_o <= 1'b1;
                        cnt      <= EN_LOAD;
                        state    <= ST_PULSE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_PULSE: begin
                    if (cnt == '0) begin
                        lcd_en_o <= 1'b0;
                        cnt      <= HOLD_LOAD;
                        state    <= ST_HOLD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
`ifdef LCD_4BIT_EN
                        if (!second_nib) begin
                            // second pass sends the low nibble with the same RS
                            second_nib <= 1'b1;
                            lcd_db_o   <= {low_nib, 4'h0};
                            cnt        <= SETUP_LOAD;
                            state      <= ST_SETUP;
                        end else begin
                            cnt   <= long_exec ? LONG_LOAD : EXEC_LOAD;
                            state <= ST_WAIT;
                        end
`else
                        cnt   <= long_exec ? LONG_LOAD : EXEC_LOAD;
                        state <= ST_WAIT;
`endif
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        ready_o <= 1'b1;
                        busy_o  <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    ready_o  <= 1'b0;
                    busy_o   <= 1'b0;
                    lcd_en_o <= 1'b0;
                    cnt      <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
